// File: rtl/ins_mem.sv
// ins_mem: 32-word x 32-bit instruction memory, bulk-loaded from a parallel image bus.
//
// On a rising clk edge with e=1 and l=1, every word mem[i] is loaded from r[i] and the
// same edge fetches word address[4:0]. The fetched word comes from the newly loaded
// data, never from the old contents. Otherwise all state holds. rst is asynchronous and
// active-high, and clears the memory and the output.
//
// Ports:
//   clk      in   system clock, rising edge active
//   rst      in   asynchronous active-high reset
//   e        in   block enable; when low, all state holds
//   l        in   load/fetch strobe (qualified by e)
//   address  in   [31:0] fetch word address; only [4:0] selects the word
//   r        in   [31:0][31:0] parallel memory image, r[i] is word i
//   q        out  [31:0] fetched instruction word
//   addr_err out  out-of-range fetch flag
//
// Build option:
//   INSMEM_ADDR_CHECK_EN  When defined, a fetch with address[31:5] != 0 still loads the
//                         memory, but returns q=0 and sets addr_err. An in-range fetch
//                         clears addr_err. When undefined, the address wraps modulo 32
//                         and addr_err is tied to 0.

module ins_mem (
  input  logic              clk,
  input  logic              rst,
  input  logic              e,
  input  logic              l,
  input  logic [31:0]       address,
  input  logic [31:0][31:0] r,
  output logic [31:0]       q,
  output logic              addr_err
);

  logic [31:0][31:0] mem_q;
  logic [4:0]        idx_q;
  logic              fetch;

  assign fetch = e & l;

  // The memory and the fetch index are both registered, and a fetch loads both of them
  // on the same edge. Reading mem_q[idx_q] therefore returns the newly loaded word
  // (write-first). q depends only on flops, so it has no combinational path from r or
  // address, and it is stable for the whole clock period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      idx_q <= '0;
    end else if (fetch) begin
      mem_q <= r;
      idx_q <= address[4:0];
    end
  end

`ifdef INSMEM_ADDR_CHECK_EN
  logic err_q;
  logic out_of_range;

  assign out_of_range = |address[31:5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (fetch) begin
      err_q <= out_of_range;
    end
  end

  // An out-of-range fetch forces the returned word to zero. The memory itself is still
  // loaded on that fetch.
  assign q        = err_q ? 32'h0 : mem_q[idx_q];
  assign addr_err = err_q;
`else
  // The upper address bits are deliberately ignored, so the address wraps modulo 32.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[31:5];

  assign q        = mem_q[idx_q];
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_ins_mem.sv
// Testbench for ins_mem.
// Expected q/addr_err values are produced by a small behavioural model and pushed to a
// scoreboard when stimulus is driven. They are popped and compared after the rising
// edge, and the word is compared again after the falling edge.

module tb_ins_mem;

  logic              clk = 1'b0;
  logic              rst;
  logic              e;
  logic              l;
  logic [31:0]       address;
  logic [31:0][31:0] r;
  logic [31:0]       q;
  logic              addr_err;

  ins_mem dut (
    .clk      (clk),
    .rst      (rst),
    .e        (e),
    .l        (l),
    .address  (address),
    .r        (r),
    .q        (q),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q_fifo[$];
  logic        exp_err_fifo[$];
  logic [31:0] m_q;
  logic        m_err;

  // Drive one cycle's inputs, advance the model, and push the expected post-edge output.
  task automatic drive(input logic ie, input logic il, input logic [31:0] ia);
    e       = ie;
    l       = il;
    address = ia;
    if (ie && il) begin
`ifdef INSMEM_ADDR_CHECK_EN
      if (ia[31:5] != 27'd0) begin
        m_q   = 32'h0;
        m_err = 1'b1;
      end else begin
        m_q   = r[ia[4:0]];
        m_err = 1'b0;
      end
`else
      m_q   = r[ia[4:0]];
      m_err = 1'b0;
`endif
    end
    exp_q_fifo.push_back(m_q);
    exp_err_fifo.push_back(m_err);
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    e       = 1'b0;
    l       = 1'b0;
    address = '0;
    r       = '0;
    m_q     = '0;
    m_err   = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if (q !== 32'h0) begin
      fails++;
      $display("FAIL reset_q: got %h, expected %h", q, 32'h0);
    end
    tests++;
    if (addr_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_err: got %b, expected 0", addr_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_fetch();
    logic [31:0] eq;
    logic        ee;
    logic        te[5];
    logic        tl[5];
    logic [31:0] ta[5];
    r[0] = 32'h0F0F0F0E;
    r[1] = 32'h0C0C0C0C;
    for (int i = 2; i <= 30; i++) r[i] = 32'h80000000;
    r[31] = 32'hFC0C0C0C;
    // Word 0, word 1, hold on l=0, top word, enable low.
    te = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tl = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ta = '{32'd0, 32'd1, 32'd2, 32'd31, 32'd0};
    for (int i = 0; i < 5; i++) begin
      drive(te[i], tl[i], ta[i]);
      @(posedge clk);
      #1;
      if (exp_q_fifo.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL fetch%0d: scoreboard empty", i);
      end else begin
        eq = exp_q_fifo.pop_front();
        ee = exp_err_fifo.pop_front();
        tests++;
        if (q !== eq) begin
          fails++;
          $display("FAIL fetch%0d_q: got %h, expected %h", i, q, eq);
        end
        tests++;
        if (addr_err !== ee) begin
          fails++;
          $display("FAIL fetch%0d_err: got %b, expected %b", i, addr_err, ee);
        end
        @(negedge clk);
        #1;
        tests++;
        if (q !== eq) begin
          fails++;
          $display("FAIL fetch%0d_negedge_q: got %h, expected %h", i, q, eq);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    // Called at the falling edge + 1; the pulse ends well before the next rising edge.
    rst = 1'b1;
    #1;
    m_q   = '0;
    m_err = 1'b0;
    tests++;
    if (q !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid_q: got %h, expected %h", q, 32'h0);
    end
    tests++;
    if (addr_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_err: got %b, expected 0", addr_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic [31:0] eq;
    logic        ee;
    logic [31:0] ta[3];
    logic        tl[3];
    for (int i = 0; i < 32; i++) r[i] = 32'hA5000000 | i;
    // Out-of-range fetch, then an in-range fetch, then an out-of-range address with l=0.
    ta = '{32'd32, 32'd3, 32'd33};
    tl = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, tl[i], ta[i]);
      @(posedge clk);
      #1;
      if (exp_q_fifo.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL oor%0d: scoreboard empty", i);
      end else begin
        eq = exp_q_fifo.pop_front();
        ee = exp_err_fifo.pop_front();
        tests++;
        if (q !== eq) begin
          fails++;
          $display("FAIL oor%0d_q: got %h, expected %h", i, q, eq);
        end
        tests++;
        if (addr_err !== ee) begin
          fails++;
          $display("FAIL oor%0d_err: got %b, expected %b", i, addr_err, ee);
        end
        @(negedge clk);
        #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] eq;
    logic        ee;
    for (int i = 0; i < 32; i++) r[i] = $urandom;
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, 1'b1, 32'($urandom_range(0, 31)));
      @(posedge clk);
      #1;
      // Change the image and address right after the edge; q must not follow them.
      for (int i = 0; i < 32; i++) r[i] = $urandom;
      address = $urandom;
      if (exp_q_fifo.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b2b%0d: scoreboard empty", c);
      end else begin
        eq = exp_q_fifo.pop_front();
        ee = exp_err_fifo.pop_front();
        tests++;
        if (q !== eq) begin
          fails++;
          $display("FAIL b2b%0d_q: got %h, expected %h", c, q, eq);
        end
        tests++;
        if (addr_err !== ee) begin
          fails++;
          $display("FAIL b2b%0d_err: got %b, expected %b", c, addr_err, ee);
        end
        @(negedge clk);
        #1;
        tests++;
        if (q !== eq) begin
          fails++;
          $display("FAIL b2b%0d_negedge_q: got %h, expected %h", c, q, eq);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_reset_mid();
    // The first fetch after reset must be a normal load and fetch.
    test_back_to_back();
    test_out_of_range();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
